calc_key_entry: RTL
===================

// Module: calc_key_entry
// PURPOSE
//  Upstream stage of the two-digit BCD calculator datapath.
//  Collects serial key codes, assembles operand A, an operator and operand B as
//  packed BCD digits, then presents them to the join/arith/split stage with a
//  valid/ready handshake. One operation is in flight at a time.
// PARAMETERS
//  NDIG  2  digits per operand; operand bus width is 4*NDIG
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  key_valid  in   1        key_code valid this cycle
//  key_code   in   4        0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQ, 15 CLR
//  key_ready  out  1        block can accept a key (key taken when valid&&ready)
//  key_err    out  1        one-cycle pulse: rejected key
//  op_valid   out  1        a_bcd/b_bcd/op valid for downstream
//  op_ready   in   1        downstream accepts operation
//  a_bcd      out  4*NDIG   operand A, MS digit in top nibble
//  b_bcd      out  4*NDIG   operand B, same packing
//  op         out  2        0 ADD, 1 SUB, 2 MUL, 3 DIV
//  disp_bcd   out  4*NDIG   only with CALC_KEY_ECHO_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state S_A, key_ready=1, key_err=0, op_valid=0, a_bcd=b_bcd=0, op=0,
//    digit counters=0. Reset in any state, including mid-handshake, wins.
//  - All outputs registered. key_ready = (state != S_ISSUE).
//  - States: S_A (enter A), S_B (enter B), S_ISSUE (present result request).
//  - Digit key in S_A/S_B: if count<NDIG, shift operand left one nibble and put
//    the digit in the LS nibble, count+1; else drop the digit and pulse key_err.
//  - S_A: operator key with cnt_a==0 -> key_err, stay. Otherwise latch op, go to S_B.
//    EQ -> key_err, stay.
//  - S_B: operator key -> overwrite op, stay, no error. EQ with cnt_b==0 ->
//    key_err, stay. Otherwise go to S_ISSUE.
//  - CLR in S_A/S_B: zero a_bcd, b_bcd, op and counters; go to S_A; no error.
//  - S_ISSUE: op_valid=1 from the cycle after EQ is accepted (latency 1).
//    a_bcd/b_bcd/op held stable while op_valid && !op_ready. Keys are ignored
//    (key_ready=0); key_valid is don't-care.
//  - Handshake op_valid&&op_ready at edge M: after M, op_valid=0, operands,
//    op and counters are zero, state S_A, key_ready=1.
//  - key_err is high for exactly the cycle after the offending key. Back-to-back
//    keys are accepted every cycle.
//  - Digit values 0-9 only enter the operands; no binary conversion here.
// CONFIGURATION
//  CALC_KEY_ECHO_EN defined: disp_bcd port present, registered. Shows a_bcd in
//    S_A and b_bcd in S_B/S_ISSUE. Reset 0. Cleared with the operands on
//    CLR/handshake.
//  Not defined: disp_bcd port and its logic absent; all other behaviour identical.
// TESTING
//  1 rst high 2 cycles -> key_ready=1, op_valid=0, a_bcd=b_bcd=0, key_err=0.
//  2 keys 1,2,ADD,2,3,EQ; op_ready=0 for 3 cycles then 1 -> op_valid 1 cycle
//    after EQ; a_bcd=8'h12, b_bcd=8'h23, op=0 stable 3 cycles; after handshake
//    op_valid=0, key_ready=1, a_bcd=0.
//  3 keys 1,2,3 -> key_err pulse after 3rd key only; a_bcd=8'h12.
//  4 ADD first -> key_err; then 4,MUL,SUB,EQ -> key_err on EQ; then 5,EQ ->
//    a_bcd=8'h04, b_bcd=8'h05, op=1.
//  5 keys 7,DIV,9,CLR -> all operands 0, state S_A; then 3,ADD,1,EQ ->
//    a_bcd=8'h03, b_bcd=8'h01, op=0.
//  6 rst during S_ISSUE with op_ready=0 -> op_valid=0 and key_ready=1 next cycle.
//    With CALC_KEY_ECHO_EN: keys 1,2,ADD -> disp_bcd 8'h01, 8'h12, then 8'h00.

Source files
------------

// File: rtl/calc_key_entry.sv
// Key-entry front end of the BCD calculator: collects operand A, operator and operand B from serial keys
// and issues them downstream. Optional display echo port is enabled with `define CALC_KEY_ECHO_EN.
module calc_key_entry #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    output logic              key_err,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [4*NDIG-1:0] a_bcd,
    output logic [4*NDIG-1:0] b_bcd,
    output logic [1:0]        op,
`ifdef CALC_KEY_ECHO_EN
    output logic [4*NDIG-1:0] disp_bcd,
`endif
    output logic [1:0]        dbg_state
);

    // Handshakes: a key moves when key_valid && key_ready at a rising edge; an operation moves
    // when op_valid && op_ready at a rising edge, and its payload is held while op_valid && !op_ready.

    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [CW-1:0]     cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic              err_q, err_d;
    logic              op_valid_q, op_valid_d;
    logic              key_ready_q, key_ready_d;
    logic              take, is_digit, is_oper, is_eq, clear_all;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        err_d     = 1'b0;
        clear_all = 1'b0;
        take      = key_valid && (state_q != S_ISSUE);
        is_digit  = (key_code <= 4'd9);
        is_oper   = (key_code >= 4'd10) && (key_code <= 4'd13);
        is_eq     = (key_code == 4'd14);

        case (state_q)
            S_A: begin
                if (take) begin
                    if (is_digit) begin
                        if (cnt_a_q < CNT_MAX) begin
                            a_d     = {a_q[4*NDIG-5:0], key_code};
                            cnt_a_d = cnt_a_q + CNT_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (is_oper) begin
                        if (cnt_a_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            // Codes 10..13 map to 0..3: low two bits plus 2, modulo 4.
                            op_d    = key_code[1:0] + 2'd2;
                            state_d = S_B;
                        end
                    end else if (is_eq) begin
                        err_d = 1'b1;
                    end else begin
                        clear_all = 1'b1;
                    end
                end
            end
            S_B: begin
                if (take) begin
                    if (is_digit) begin
                        if (cnt_b_q < CNT_MAX) begin
                            b_d     = {b_q[4*NDIG-5:0], key_code};
                            cnt_b_d = cnt_b_q + CNT_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (is_oper) begin
                        op_d = key_code[1:0] + 2'd2;
                    end else if (is_eq) begin
                        if (cnt_b_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        clear_all = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    clear_all = 1'b1;
                end
            end
            default: begin
                clear_all = 1'b1;
            end
        endcase

        if (clear_all) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = 2'd0;
            cnt_a_d = '0;
            cnt_b_d = '0;
        end

        op_valid_d  = (state_d == S_ISSUE);
        key_ready_d = (state_d != S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'd0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            err_q       <= 1'b0;
            op_valid_q  <= 1'b0;
            key_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            err_q       <= err_d;
            op_valid_q  <= op_valid_d;
            key_ready_q <= key_ready_d;
        end
    end

`ifdef CALC_KEY_ECHO_EN
    logic [4*NDIG-1:0] disp_q, disp_d;

    always_comb begin
        disp_d = (state_d == S_A) ? a_d : b_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign disp_bcd = disp_q;
`endif

    assign key_ready = key_ready_q;
    assign key_err   = err_q;
    assign op_valid  = op_valid_q;
    assign a_bcd     = a_q;
    assign b_bcd     = b_q;
    assign op        = op_q;
    assign dbg_state = state_q;

endmodule
